// File: rtl/jtcps1_stars_rom.sv
// ROM responder for the two CPS1 star-field layers: one-word cache per layer,
// misses fetched through a single shared memory port with round-robin arbitration.
module jtcps1_stars_rom #(
  parameter int unsigned AW    = 22,
  parameter int unsigned BASE0 = 0,
  parameter int unsigned BASE1 = 'h2000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          star0_cs,
  input  logic [12:0]   star0_addr,
  output logic [31:0]   star0_data,
  output logic          star0_ok,
  input  logic          star1_cs,
  input  logic [12:0]   star1_addr,
  output logic [31:0]   star1_data,
  output logic          star1_ok,
  output logic [AW-1:0] mem_addr,
  output logic          mem_req,
  input  logic          mem_rdy,
  input  logic [31:0]   mem_data
);

  localparam logic [AW-1:0] Base0W = AW'(BASE0);
  localparam logic [AW-1:0] Base1W = AW'(BASE1);

  typedef enum logic {StIdle, StWait} state_e;

  state_e             state_q, state_d;
  logic               sel_q, sel_d;
  logic               last_q, last_d;
  logic [12:0]        pend_tag_q, pend_tag_d;
  logic [AW-1:0]      mem_addr_q, mem_addr_d;
  logic               mem_req_q, mem_req_d;
  logic [1:0][12:0]   tag_q, tag_d;
  logic [1:0][31:0]   data_q, data_d;
  logic [1:0]         valid_q, valid_d;
  logic [1:0]         ok;
  logic [1:0]         need;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      sel_q      <= 1'b0;
      last_q     <= 1'b1;  // layer 0 wins the first tie
      pend_tag_q <= '0;
      mem_addr_q <= '0;
      mem_req_q  <= 1'b0;
      tag_q      <= '0;
      data_q     <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      pend_tag_q <= pend_tag_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    // Hit is combinational so ok drops in the same cycle the address moves
    ok[0] = star0_cs & valid_q[0] & (tag_q[0] == star0_addr);
    ok[1] = star1_cs & valid_q[1] & (tag_q[1] == star1_addr);
    need  = {star1_cs & ~ok[1], star0_cs & ~ok[0]};

    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    pend_tag_d = pend_tag_q;
    mem_addr_d = mem_addr_q;
    mem_req_d  = mem_req_q;
    tag_d      = tag_q;
    data_d     = data_q;
    valid_d    = valid_q;

    case (state_q)
      StIdle: begin
        if (|need) begin
          sel_d      = (&need) ? ~last_q : need[1];
          pend_tag_d = sel_d ? star1_addr : star0_addr;
          mem_addr_d = (sel_d ? Base1W : Base0W) + AW'(pend_tag_d);
          mem_req_d  = 1'b1;
          state_d    = StWait;
        end
      end
      StWait: begin
        // Fill lands under the tag captured at issue, even if the client moved on
        if (mem_rdy) begin
          data_d[sel_q]  = mem_data;
          tag_d[sel_q]   = pend_tag_q;
          valid_d[sel_q] = 1'b1;
          last_d         = sel_q;
          mem_req_d      = 1'b0;
          state_d        = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign star0_ok   = ok[0];
  assign star1_ok   = ok[1];
  assign star0_data = data_q[0];
  assign star1_data = data_q[1];
  assign mem_addr   = mem_addr_q;
  assign mem_req    = mem_req_q;

endmodule

// File: tb/tb_jtcps1_stars_rom.sv
// Self-checking bench for jtcps1_stars_rom: behavioural cache/arbiter model,
// memory responder with random latency, directed scenarios plus random traffic.
module tb_jtcps1_stars_rom;

  localparam int AW    = 22;
  localparam int BASE0 = 0;
  localparam int BASE1 = 'h2000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          star0_cs = 1'b0, star1_cs = 1'b0;
  logic [12:0]   star0_addr = '0, star1_addr = '0;
  logic [31:0]   star0_data, star1_data;
  logic          star0_ok, star1_ok;
  logic [AW-1:0] mem_addr;
  logic          mem_req;
  logic          mem_rdy = 1'b0;
  logic [31:0]   mem_data = '0;

  jtcps1_stars_rom #(.AW(AW), .BASE0(BASE0), .BASE1(BASE1)) dut (
    .clk        (clk),
    .rst        (rst),
    .star0_cs   (star0_cs),
    .star0_addr (star0_addr),
    .star0_data (star0_data),
    .star0_ok   (star0_ok),
    .star1_cs   (star1_cs),
    .star1_addr (star1_addr),
    .star1_data (star1_data),
    .star1_ok   (star1_ok),
    .mem_addr   (mem_addr),
    .mem_req    (mem_req),
    .mem_rdy    (mem_rdy),
    .mem_data   (mem_data)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: cache contents, outstanding fetch, round-robin history
  logic [12:0]   mt [2];
  logic [31:0]   md [2];
  bit            mv [2];
  bit            m_busy;
  int            m_c;
  int            m_last;
  logic [12:0]   m_tag;
  logic [AW-1:0] m_addr;
  int            req_count;
  logic [AW-1:0] addr_log [$];
  int            grant_log [$];

  // Responder / previous-cycle stimulus
  bit          p_rdy;
  bit          p_need [2];
  logic [31:0] p_mdata;
  bit          in_req;
  int          cnt;
  int          rdy_delay = -1;
  bit          spurious = 1'b0;
  bit          force_rdy = 1'b0;
  bit          force_data_en = 1'b0;
  logic [31:0] force_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] memfn(input logic [AW-1:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic bit mok(input int c);
    if (c == 0) return star0_cs && mv[0] && (mt[0] == star0_addr);
    return star1_cs && mv[1] && (mt[1] == star1_addr);
  endfunction

  task automatic check_now();
    chk("star0_ok", star0_ok, mok(0));
    chk("star1_ok", star1_ok, mok(1));
    chk("star0_data", star0_data, md[0]);
    chk("star1_data", star1_data, md[1]);
  endtask

  // One clock: drive memory side, let the edge pass, advance model, compare
  task automatic step();
    bit rdy;
    rdy = 1'b0;
    if (mem_req) begin
      if (!in_req) begin
        in_req = 1'b1;
        cnt = (rdy_delay >= 0) ? rdy_delay : int'($urandom_range(0, 3));
      end
      if (cnt == 0) begin
        rdy = 1'b1;
        in_req = 1'b0;
      end else cnt--;
    end else begin
      in_req = 1'b0;
      rdy = force_rdy || (spurious && ($urandom_range(0, 7) == 0));
      force_rdy = 1'b0;
    end
    mem_rdy  = rdy;
    mem_data = rdy ? (force_data_en ? force_data : memfn(mem_addr)) : $urandom();
    p_rdy     = rdy;
    p_mdata   = mem_data;
    p_need[0] = star0_cs && !mok(0);
    p_need[1] = star1_cs && !mok(1);
    @(negedge clk);
    if (m_busy) begin
      if (p_rdy) begin
        mt[m_c] = m_tag;
        md[m_c] = p_mdata;
        mv[m_c] = 1'b1;
        m_last  = m_c;
        m_busy  = 1'b0;
      end
    end else if (p_need[0] || p_need[1]) begin
      m_c    = (p_need[0] && p_need[1]) ? 1 - m_last : (p_need[0] ? 0 : 1);
      m_tag  = (m_c == 1) ? star1_addr : star0_addr;
      m_addr = AW'((m_c == 1) ? BASE1 : BASE0) + AW'(m_tag);
      m_busy = 1'b1;
      req_count++;
      addr_log.push_back(m_addr);
      grant_log.push_back(m_c);
    end
    chk("mem_req", mem_req, m_busy);
    if (m_busy) chk("mem_addr", mem_addr, m_addr);
    check_now();
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    mem_rdy = 1'b0;
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_ok0", star0_ok, 1'b0);
    chk("rst_ok1", star1_ok, 1'b0);
    chk("rst_data0", star0_data, 32'h0);
    chk("rst_data1", star1_data, 32'h0);
    for (int i = 0; i < 2; i++) begin
      mt[i] = '0; md[i] = '0; mv[i] = 1'b0;
    end
    m_busy = 1'b0; m_last = 1; req_count = 0; in_req = 1'b0;
    addr_log.delete();
    grant_log.delete();
    repeat (2) @(negedge clk);
    chk("rst_hold_mem_addr", mem_addr, '0);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int n0;
    // Single miss on layer 0
    do_reset();
    star0_cs = 1'b1; star0_addr = 13'h123; star1_cs = 1'b0;
    rdy_delay = 2; force_data_en = 1'b1; force_data = 32'hDEADBEEF;
    n = 0;
    while (!star0_ok && n < 20) begin step(); n++; end
    chk("t1_ok0", star0_ok, 1'b1);
    chk("t1_data0", star0_data, 32'hDEADBEEF);
    chk("t1_addr", (addr_log.size() > 0) ? addr_log[0] : '1, 22'h000123);
    repeat (5) step();
    chk("t1_req_count", req_count, 1);
    force_data_en = 1'b0;

    // Both layers miss from reset
    do_reset();
    star0_cs = 1'b1; star0_addr = 13'h10; star1_cs = 1'b1; star1_addr = 13'h20;
    rdy_delay = -1;
    repeat (20) step();
    chk("t2_nreq", addr_log.size(), 2);
    if (addr_log.size() >= 2) begin
      chk("t2_addr0", addr_log[0], 22'h000010);
      chk("t2_addr1", addr_log[1], 22'h002020);
    end
    chk("t2_data0", star0_data, 32'hFFEF0010);
    chk("t2_data1", star1_data, 32'hDFDF2020);

    // Hit/miss replacement on layer 0
    star1_cs = 1'b0;
    star0_addr = 13'h11;
    #1 chk("t3_ok_drop", star0_ok, 1'b0);
    repeat (10) step();
    chk("t3_ok11", star0_ok, 1'b1);
    chk("t3_data11", star0_data, 32'hFFEE0011);
    star0_addr = 13'h10;
    #1 chk("t3_ok_back", star0_ok, 1'b0);
    repeat (10) step();
    chk("t3_refetch", addr_log[addr_log.size()-1], 22'h000010);
    chk("t3_ok10", star0_ok, 1'b1);

    // Address change while the layer 1 fetch is outstanding
    star0_cs = 1'b0; star1_cs = 1'b1; star1_addr = 13'h5; rdy_delay = 3;
    n0 = req_count;
    step();
    star1_addr = 13'h6;
    n = 0;
    while (req_count < n0 + 2 && n < 20) begin step(); n++; end
    chk("t4_nreq", req_count, n0 + 2);
    if (addr_log.size() >= n0 + 2) begin
      chk("t4_addr5", addr_log[n0], 22'h002005);
      chk("t4_addr6", addr_log[n0+1], 22'h002006);
    end
    repeat (10) step();
    chk("t4_ok1", star1_ok, 1'b1);
    chk("t4_data1", star1_data, 32'hDFF92006);

    // Reset with a fetch in flight, then a stray mem_rdy
    star1_cs = 1'b0; star0_cs = 1'b1; star0_addr = 13'h77; rdy_delay = 8;
    step(); step();
    chk("t5_req_before", mem_req, 1'b1);
    do_reset();
    star0_cs = 1'b0; force_rdy = 1'b1;
    repeat (3) step();
    star0_cs = 1'b1;
    #1 chk("t5_ok_after", star0_ok, 1'b0);
    repeat (10) step();

    // Sustained dual misses must alternate grants
    do_reset();
    rdy_delay = -1; star0_cs = 1'b1; star1_cs = 1'b1;
    n = 0;
    while (req_count < 64 && n < 1000) begin
      star0_addr = 13'(n);
      star1_addr = 13'(n + 'h1000);
      step();
      n++;
    end
    chk("t6_nreq", (req_count >= 64), 1'b1);
    if (grant_log.size() > 0) chk("t6_first", grant_log[0], 0);
    for (int i = 1; i < 64 && i < grant_log.size(); i++)
      chk("t6_alt", grant_log[i], 1 - grant_log[i-1]);

    // Random traffic with stray strobes
    spurious = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) star0_cs = 1'($urandom());
      if ($urandom_range(0, 3) == 0) star1_cs = 1'($urandom());
      if ($urandom_range(0, 2) == 0) star0_addr = 13'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) star1_addr = 13'($urandom_range(0, 3) + 'h1ffe);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
